// File: rtl/trig_capture.sv
// Trigger capture buffer: circular pre-trigger history plus post-trigger window, replayed oldest-first.
// Readout: first word 2 cycles after READ, one word per cycle; a 2-entry output skid holds data under m_ready stalls.
module trig_capture #(
   parameter int CHANNEL_NUM = 4,
   parameter int BIT_NUM     = 16,
   parameter int DEPTH_LOG2  = 10
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           arm,
   input  logic                           abort,
   input  logic [DEPTH_LOG2-1:0]          pre_len,
   input  logic [DEPTH_LOG2:0]            post_len,
   input  logic [BIT_NUM*CHANNEL_NUM-1:0] idata,
   input  logic                           idata_valid,
   input  logic                           trig,
   output logic [BIT_NUM*CHANNEL_NUM-1:0] m_data,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic                           m_last,
   output logic                           busy,
   output logic                           done
);

   localparam int W     = BIT_NUM * CHANNEL_NUM;
   localparam int AW    = DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [AW-1:0] A_ONE   = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] C_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] C_DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [CW:0]   X_DEPTH = {2'b01, {AW{1'b0}}};

   typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, READ} state_t;
   state_t state;

   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  ram_q;
   logic [W-1:0]  sk_data;
   logic [AW-1:0] p_len;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] pre_cnt;
   logic [AW-1:0] t_addr;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] q_len;
   logic [CW-1:0] post_cnt;
   logic [CW-1:0] rd_left;
   logic [CW-1:0] rd_total;
   logic [CW-1:0] q_req;
   logic [CW-1:0] q_fit;
   logic [CW:0]   pq_sum;
   logic          rd_pend;
   logic          rd_last_q;
   logic          sk_valid;
   logic          sk_last;
   logic          samp_we;
   logic          rd_en;
   logic          pop;
   logic [1:0]    occ;

   always_comb begin
      q_req    = (post_len == '0) ? C_ONE : post_len;
      pq_sum   = {2'b00, pre_len} + {1'b0, q_req};
      q_fit    = (pq_sum > X_DEPTH) ? (C_DEPTH - {1'b0, pre_len}) : q_req;
      rd_total = {1'b0, p_len} + q_len;
      pop      = m_valid && m_ready;
      // Words held or in flight toward the output; a read is issued only if it will have a slot.
      occ      = {1'b0, m_valid} + {1'b0, sk_valid} + {1'b0, rd_pend};
      samp_we  = !rst && !abort && idata_valid &&
                 ((state == PRE && p_len != '0) || state == WAIT || state == POST);
      rd_en    = !rst && !abort && state == READ && rd_left != '0 &&
                 ((occ - {1'b0, pop}) < 2'd2);
   end

   always_ff @(posedge clk) begin
      if (samp_we)
         mem[wr_ptr] <= idata;
      if (rd_en)
         ram_q <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         p_len     <= '0;
         q_len     <= '0;
         wr_ptr    <= '0;
         pre_cnt   <= '0;
         t_addr    <= '0;
         post_cnt  <= '0;
         rd_addr   <= '0;
         rd_left   <= '0;
         rd_pend   <= 1'b0;
         rd_last_q <= 1'b0;
         sk_valid  <= 1'b0;
         sk_last   <= 1'b0;
         sk_data   <= '0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (abort) begin
         state    <= IDLE;
         rd_left  <= '0;
         rd_pend  <= 1'b0;
         sk_valid <= 1'b0;
         sk_last  <= 1'b0;
         m_data   <= '0;
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done    <= 1'b0;
         rd_pend <= rd_en;
         if (rd_en) begin
            rd_addr   <= rd_addr + A_ONE;
            rd_left   <= rd_left - C_ONE;
            rd_last_q <= (rd_left == C_ONE);
         end

         if (!m_valid || pop) begin
            if (sk_valid) begin
               m_data   <= sk_data;
               m_last   <= sk_last;
               m_valid  <= 1'b1;
               sk_valid <= rd_pend;
               sk_data  <= ram_q;
               sk_last  <= rd_last_q;
            end else begin
               m_valid <= rd_pend;
               m_last  <= rd_pend && rd_last_q;
               if (rd_pend)
                  m_data <= ram_q;
            end
         end else if (rd_pend) begin
            sk_valid <= 1'b1;
            sk_data  <= ram_q;
            sk_last  <= rd_last_q;
         end

         case (state)
            IDLE: begin
               busy <= arm;
               if (arm) begin
                  p_len   <= pre_len;
                  q_len   <= q_fit;
                  wr_ptr  <= '0;
                  pre_cnt <= '0;
                  state   <= PRE;
               end
            end
            PRE: begin
               if (p_len == '0) begin
                  state <= WAIT;
               end else if (idata_valid) begin
                  wr_ptr  <= wr_ptr + A_ONE;
                  pre_cnt <= pre_cnt + A_ONE;
                  if (pre_cnt + A_ONE == p_len)
                     state <= WAIT;
               end
            end
            WAIT: begin
               if (idata_valid) begin
                  wr_ptr <= wr_ptr + A_ONE;
                  if (trig) begin
                     t_addr   <= wr_ptr;
                     post_cnt <= C_ONE;
                     if (q_len == C_ONE) begin
                        state   <= READ;
                        rd_addr <= wr_ptr - p_len;
                        rd_left <= rd_total;
                     end else begin
                        state <= POST;
                     end
                  end
               end
            end
            POST: begin
               if (idata_valid) begin
                  wr_ptr   <= wr_ptr + A_ONE;
                  post_cnt <= post_cnt + C_ONE;
                  if (post_cnt + C_ONE == q_len) begin
                     state   <= READ;
                     rd_addr <= t_addr - p_len;
                     rd_left <= rd_total;
                  end
               end
            end
            READ: begin
               // busy stays high through the done cycle and drops from IDLE next cycle.
               if (pop && m_last) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/trig_capture.md
Name: trig_capture

Overview:
- Consumer end of the sample/trigger stream.
- Accepts the registered multi-channel sample bus, its valid and the aligned trigger flag from the upstream trigger generator.
- Keeps a circular pre-trigger history and records a programmable post-trigger window.
- Replays the captured window in time order on a valid/ready stream toward the readout/DMA path.

Parameters:
CHANNEL_NUM, 4, number of channels packed in a sample word
BIT_NUM, 16, bits per channel
DEPTH_LOG2, 10, log2 of capture buffer depth (DEPTH = 2**DEPTH_LOG2 sample words)

Ports:
clk  input  1  single clock for all logic
rst  input  1  synchronous reset, active-high
arm  input  1  one-cycle start request; latches pre_len/post_len
abort  input  1  return to IDLE from any state; no done pulse
pre_len  input  DEPTH_LOG2  samples kept before the trigger sample
post_len  input  DEPTH_LOG2+1  samples from the trigger sample onward (trigger sample included)
idata  input  BIT_NUM*CHANNEL_NUM  sample word, aligned with idata_valid and trig
idata_valid  input  1  sample qualifier
trig  input  1  trigger flag for the current sample; used only when idata_valid=1
m_data  output  BIT_NUM*CHANNEL_NUM  readout word
m_valid  output  1  readout word valid
m_ready  input  1  downstream accept
m_last  output  1  marks the final word of the window
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (rst=1 at a clock edge, in any state including mid-readout):
  - state=IDLE; write pointer, counters and output register cleared.
  - m_data=0, m_valid=0, m_last=0, busy=0, done=0.
- Config latch on arm in IDLE:
  - Latch P=pre_len and Q=post_len.
  - If Q=0, Q becomes 1.
  - If P+Q>DEPTH, Q is clamped to DEPTH-P.
  - arm outside IDLE is ignored.
- States:
  - IDLE: no writes. arm -> PRE, with write pointer and fill count cleared.
  - PRE: write every valid sample and count it. trig is ignored. When the count reaches P -> WAIT; if P=0, go straight to WAIT on the next cycle.
  - WAIT: write every valid sample circularly; the pointer wraps modulo DEPTH. A valid sample with trig=1 is written, its address is latched as T, post count=1, then -> POST. If Q=1, go -> READ instead.
  - POST: write every valid sample. When the post count reaches Q -> READ. trig is ignored.
  - READ: no writes; idata is dropped. Read addresses run from (T-P) mod DEPTH for P+Q words, incrementing with wrap. After the word with m_last=1 is accepted: done=1 for one cycle, then -> IDLE.
- abort:
  - Any state -> IDLE next cycle; m_valid drops; done stays 0.
  - abort has priority over arm, trig and m_ready in the same cycle; rst has priority over abort.
- Storage: simple dual-port RAM, registered read (1-cycle latency), plus an output skid stage.
  - First m_valid no later than 3 cycles after entering READ.
  - m_data/m_last hold stable while m_valid=1 and m_ready=0.
  - Full throughput (one word per cycle) while m_ready=1.
  - m_valid stays high between words unless m_ready stalls drain the pipeline.
- Word order: oldest pre-trigger sample first, trigger sample at index P, last post sample at index P+Q-1.
- idata_valid=0 cycles: nothing written, counters hold, trig ignored.
- busy=1 from the cycle after arm until the cycle done is asserted inclusive.

Test Plan:
- Basic capture: DEPTH_LOG2=4, P=3, Q=4, ramp idata=n per channel, trig at n=10 -> 7 words 7,8,9,10,11,12,13; m_last on 13; single done pulse.
- Wrap-around: P=3, Q=4, trig at n=30 (pointer has wrapped) -> words 27..33 in order, no address glitch at the wrap.
- Early trigger ignored: trig at n=1 during PRE with P=3 -> no capture; a later trig at n=8 gives words 5..11.
- Backpressure and gaps: random m_ready at 50% and idata_valid gaps -> identical word sequence; data held stable while stalled; no drops or duplicates.
- Clamp and P=0: P=10, Q=12 on DEPTH=16 clamps Q to 6 -> 16 words. P=0, Q=1 with trig at n=5 -> single word 5 with m_last=1.
- Abort/reset mid-readout: abort after the 2nd accepted word -> m_valid=0 next cycle, no done, busy=0. A re-arm then captures correctly. The same check with rst=1 gives all outputs 0.
